// File: rtl/la_cmd_pkg.sv
// Shared definitions for the logic-analyser host-command controller:
// opcodes, reply codes, FSM states, configuration defaults and the
// payload-length lookup used by the parser.
package la_cmd_pkg;

    localparam logic [7:0] OP_ARM       = 8'h01;
    localparam logic [7:0] OP_SET_MASK  = 8'h02;
    localparam logic [7:0] OP_SET_VALUE = 8'h03;
    localparam logic [7:0] OP_SET_COUNT = 8'h04;
    localparam logic [7:0] OP_SET_DIV   = 8'h05;
    localparam logic [7:0] OP_STATUS    = 8'h06;
    localparam logic [7:0] OP_SOFT_RST  = 8'hFF;

    localparam logic [7:0] RSP_ACK = 8'hAA;
    localparam logic [7:0] RSP_NAK = 8'h55;

    localparam logic [7:0] DEF_MASK  = 8'h00;
    localparam logic [7:0] DEF_VALUE = 8'h00;
    localparam logic [7:0] DEF_DIV   = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_EXEC    = 2'd2
    } state_t;

    // Number of payload bytes following an opcode (unknown opcodes report 0).
    function automatic logic [1:0] payload_len(input logic [7:0] op);
        case (op)
            OP_SET_MASK, OP_SET_VALUE, OP_SET_DIV: payload_len = 2'd1;
            OP_SET_COUNT:                          payload_len = 2'd2;
            default:                               payload_len = 2'd0;
        endcase
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        case (op)
            OP_ARM, OP_SET_MASK, OP_SET_VALUE, OP_SET_COUNT,
            OP_SET_DIV, OP_STATUS, OP_SOFT_RST: op_known = 1'b1;
            default:                            op_known = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/la_cmd_ctrl_if.sv
// Bundle of the command controller's UART, capture-engine and config signals.
// master: the controller (drives tx, pulses and config registers).
// slave:  the host/UART/capture side (drives rx bytes, tx_busy, capture status).
interface la_cmd_ctrl_if #(parameter int COUNT_W = 16);
    logic               rx_data_fresh;
    logic [7:0]         rx_data;
    logic               tx_busy;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               capture_busy;
    logic               capture_done;
    logic               soft_rst;
    logic               arm;
    logic [7:0]         trig_mask;
    logic [7:0]         trig_value;
    logic [COUNT_W-1:0] sample_count;
    logic [7:0]         clk_div;

    modport master (
        input  rx_data_fresh, rx_data, tx_busy, capture_busy, capture_done,
        output tx_start, tx_data, soft_rst, arm,
               trig_mask, trig_value, sample_count, clk_div
    );

    modport slave (
        output rx_data_fresh, rx_data, tx_busy, capture_busy, capture_done,
        input  tx_start, tx_data, soft_rst, arm,
               trig_mask, trig_value, sample_count, clk_div
    );
endinterface

// File: rtl/la_resp_slot.sv
// One-deep reply holding register in front of the UART transmitter.
// Latency: tx_start earliest the cycle after load; slot empties on that cycle.
// Backpressure: holds while tx_busy=1; a load into a full slot overwrites and sets sticky overrun.
// Ports: clk/rst; load/load_dat in; ovr_clr in; tx_busy in; tx_start/tx_data out; overrun out.
module la_resp_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_dat,
    input  logic       ovr_clr,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       overrun
);
    logic       full_q;
    logic [7:0] data_q;
    logic       ovr_q;
    logic       send;

    // A reply leaving in the same cycle a new one arrives is not lost,
    // so that case does not count as an overrun.
    assign send     = full_q & ~tx_busy;
    assign tx_start = send;
    assign tx_data  = data_q;
    assign overrun  = ovr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= 8'h00;
            ovr_q  <= 1'b0;
        end else begin
            if (load) begin
                data_q <= load_dat;
            end
            full_q <= load | (full_q & ~send);
            // Set wins over clear so a STATUS reply that itself overruns is remembered.
            if (load && full_q && !send) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/la_cmd_ctrl.sv
// Host-command parser: UART rx bytes -> capture config registers, arm/soft-reset pulses, 1-byte replies.
// Latency: register update/pulse visible the cycle after the final byte's edge; reply tx_start one cycle later.
// Backpressure: rx never stalled; replies wait in a one-deep slot while tx_busy=1 (overwrite + overrun when full).
// Ports: clk, rst (sync, active-high); bus = la_cmd_ctrl_if.master (rx/tx UART, capture status, config outputs).
module la_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int COUNT_W        = 16,
    parameter int DEF_COUNT      = 1024
) (
    input  logic           clk,
    input  logic           rst,
    la_cmd_ctrl_if.master  bus
);
    import la_cmd_pkg::*;

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_nxt;
    logic [7:0]         op_q;
    logic [1:0]         rem_q;
    logic [7:0]         lsb_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [7:0]         mask_q, value_q, div_q;
    logic [COUNT_W-1:0] count_q;

    logic               rsp_load;
    logic [7:0]         rsp_dat;
    logic               ovr_clr;
    logic               overrun;
    logic               arm_p, soft_rst_p;

    always_comb begin
        state_nxt  = state_q;
        rsp_load   = 1'b0;
        rsp_dat    = RSP_ACK;
        ovr_clr    = 1'b0;
        arm_p      = 1'b0;
        soft_rst_p = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_data_fresh) begin
                    if (!op_known(bus.rx_data)) begin
                        rsp_load = 1'b1;
                        rsp_dat  = RSP_NAK;
                    end else if (payload_len(bus.rx_data) == 2'd0) begin
                        state_nxt = ST_EXEC;
                    end else begin
                        state_nxt = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                // A byte arriving on the last allowed cycle still counts.
                if (bus.rx_data_fresh) begin
                    if (rem_q == 2'd1) begin
                        state_nxt = ST_EXEC;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_IDLE;
                case (op_q)
                    OP_ARM: begin
                        rsp_load = 1'b1;
                        if (bus.capture_busy) begin
                            rsp_dat = RSP_NAK;
                        end else begin
                            arm_p = 1'b1;
                        end
                    end
                    OP_STATUS: begin
                        rsp_load = 1'b1;
                        rsp_dat  = {5'b0, overrun, bus.capture_busy, bus.capture_done};
                        ovr_clr  = 1'b1;
                    end
                    OP_SOFT_RST: begin
                        soft_rst_p = 1'b1;
                        ovr_clr    = 1'b1;
                    end
                    default: rsp_load = 1'b1;
                endcase
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Config registers change on the edge that samples the final byte so the
    // new values are already visible during the EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 8'h00;
            rem_q   <= 2'd0;
            lsb_q   <= 8'h00;
            tmo_q   <= '0;
            mask_q  <= DEF_MASK;
            value_q <= DEF_VALUE;
            div_q   <= DEF_DIV;
            count_q <= COUNT_W'(DEF_COUNT);
        end else begin
            state_q <= state_nxt;
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_data_fresh) begin
                        op_q  <= bus.rx_data;
                        rem_q <= payload_len(bus.rx_data);
                        tmo_q <= '0;
                        if (bus.rx_data == OP_SOFT_RST) begin
                            mask_q  <= DEF_MASK;
                            value_q <= DEF_VALUE;
                            div_q   <= DEF_DIV;
                            count_q <= COUNT_W'(DEF_COUNT);
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (bus.rx_data_fresh) begin
                        tmo_q <= '0;
                        rem_q <= rem_q - 2'd1;
                        if (rem_q == 2'd1) begin
                            case (op_q)
                                OP_SET_MASK:  mask_q  <= bus.rx_data;
                                OP_SET_VALUE: value_q <= bus.rx_data;
                                OP_SET_DIV:   div_q   <= bus.rx_data;
                                OP_SET_COUNT: count_q <= COUNT_W'({bus.rx_data, lsb_q});
                                default:      ;
                            endcase
                        end else begin
                            lsb_q <= bus.rx_data;
                        end
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    la_resp_slot u_resp_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (rsp_load),
        .load_dat (rsp_dat),
        .ovr_clr  (ovr_clr),
        .tx_busy  (bus.tx_busy),
        .tx_start (bus.tx_start),
        .tx_data  (bus.tx_data),
        .overrun  (overrun)
    );

    assign bus.arm          = arm_p;
    assign bus.soft_rst     = soft_rst_p;
    assign bus.trig_mask    = mask_q;
    assign bus.trig_value   = value_q;
    assign bus.sample_count = count_q;
    assign bus.clk_div      = div_q;
endmodule

// File: tb/tb_la_cmd_ctrl.sv
// Directed bench for la_cmd_ctrl: command parsing, replies, timeout, overrun.
module tb_la_cmd_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   tx_cnt      = 0;
    int   arm_cnt     = 0;
    int   srst_cnt    = 0;

    always #5 clk = ~clk;

    la_cmd_ctrl_if #(.COUNT_W(16)) bus ();

    la_cmd_ctrl #(
        .TIMEOUT_CYCLES (100),
        .COUNT_W        (16),
        .DEF_COUNT      (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (bus.tx_start === 1'b1) tx_cnt++;
        if (bus.arm === 1'b1) arm_cnt++;
        if (bus.soft_rst === 1'b1) srst_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in the cycle after the byte's sampling edge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data_fresh = 1'b1;
        bus.rx_data       = b;
        tick();
        bus.rx_data_fresh = 1'b0;
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.tx_start === 1'b1) begin
                found = 1'b1;
                check({tag, "_dat"}, {24'b0, bus.tx_data}, {24'b0, exp});
            end
            tick();
        end
        check({tag, "_seen"}, {31'b0, found}, 32'd1);
    endtask

    initial begin
        int tx0, arm0, srst0;
        rst               = 1'b1;
        bus.rx_data_fresh = 1'b0;
        bus.rx_data       = 8'h00;
        bus.tx_busy       = 1'b0;
        bus.capture_busy  = 1'b0;
        bus.capture_done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        check("rst_mask",  {24'b0, bus.trig_mask},  32'h00);
        check("rst_value", {24'b0, bus.trig_value}, 32'h00);
        check("rst_count", {16'b0, bus.sample_count}, 32'd1024);
        check("rst_div",   {24'b0, bus.clk_div},    32'h00);
        check("rst_txs",   {31'b0, bus.tx_start},   32'd0);
        check("rst_txd",   {24'b0, bus.tx_data},    32'h00);
        check("rst_arm",   {31'b0, bus.arm},        32'd0);
        check("rst_srst",  {31'b0, bus.soft_rst},   32'd0);

        // SET_MASK 0xF0 with transmitter busy, then release
        bus.tx_busy = 1'b1;
        send_byte(8'h02);
        check("mask_early", {24'b0, bus.trig_mask}, 32'h00);
        send_byte(8'hF0);
        check("mask_f0", {24'b0, bus.trig_mask}, 32'hF0);
        check("mask_txs_exec", {31'b0, bus.tx_start}, 32'd0);
        tick();
        check("mask_txs_busy", {31'b0, bus.tx_start}, 32'd0);
        tick();
        bus.tx_busy = 1'b0;
        #1;
        check("mask_txs", {31'b0, bus.tx_start}, 32'd1);
        check("mask_txd", {24'b0, bus.tx_data}, 32'hAA);
        tick();
        check("mask_txs_done", {31'b0, bus.tx_start}, 32'd0);

        // SET_COUNT 0x1234 (LSB first)
        send_byte(8'h04);
        send_byte(8'h34);
        send_byte(8'h12);
        check("count_1234", {16'b0, bus.sample_count}, 32'h1234);
        wait_tx("count_ack", 8'hAA);

        // SOFT_RST in IDLE
        tx0   = tx_cnt;
        srst0 = srst_cnt;
        send_byte(8'hFF);
        check("srst_pulse", {31'b0, bus.soft_rst}, 32'd1);
        check("srst_count", {16'b0, bus.sample_count}, 32'd1024);
        check("srst_mask",  {24'b0, bus.trig_mask}, 32'h00);
        tick();
        check("srst_low", {31'b0, bus.soft_rst}, 32'd0);
        repeat (3) tick();
        check("srst_noreply", tx_cnt, tx0);
        check("srst_once", srst_cnt, srst0 + 1);

        // 0xFF as payload data
        srst0 = srst_cnt;
        send_byte(8'h02);
        send_byte(8'hFF);
        check("maskff", {24'b0, bus.trig_mask}, 32'hFF);
        check("maskff_nosrst", {31'b0, bus.soft_rst}, 32'd0);
        wait_tx("maskff_ack", 8'hAA);
        check("maskff_srst_cnt", srst_cnt, srst0);

        // SET_VALUE, then reset mid-command
        send_byte(8'h03);
        send_byte(8'hA5);
        check("value_a5", {24'b0, bus.trig_value}, 32'hA5);
        wait_tx("value_ack", 8'hAA);
        send_byte(8'h03);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_value", {24'b0, bus.trig_value}, 32'h00);
        check("midrst_mask",  {24'b0, bus.trig_mask}, 32'h00);
        send_byte(8'h06);
        wait_tx("midrst_status", 8'h00);

        // ARM idle and busy
        arm0 = arm_cnt;
        send_byte(8'h01);
        check("arm_pulse", {31'b0, bus.arm}, 32'd1);
        wait_tx("arm_ack", 8'hAA);
        check("arm_once", arm_cnt, arm0 + 1);
        bus.capture_busy = 1'b1;
        send_byte(8'h01);
        check("arm_busy_nopulse", {31'b0, bus.arm}, 32'd0);
        wait_tx("arm_nak", 8'h55);
        check("arm_busy_cnt", arm_cnt, arm0 + 1);
        bus.capture_busy = 1'b0;

        // Payload byte arriving on the last cycle before timeout
        send_byte(8'h04);
        send_byte(8'h10);
        repeat (98) tick();
        send_byte(8'h56);
        check("tmo_edge_count", {16'b0, bus.sample_count}, 32'h5610);
        wait_tx("tmo_edge_ack", 8'hAA);

        // Full timeout discards partial command
        tx0 = tx_cnt;
        send_byte(8'h04);
        send_byte(8'h10);
        repeat (100) tick();
        check("tmo_count", {16'b0, bus.sample_count}, 32'h5610);
        check("tmo_noreply", tx_cnt, tx0);
        bus.capture_busy = 1'b1;
        bus.capture_done = 1'b1;
        send_byte(8'h06);
        wait_tx("tmo_status", 8'h03);
        bus.capture_busy = 1'b0;
        bus.capture_done = 1'b0;

        // Overrun: two replies while transmitter busy
        bus.tx_busy = 1'b1;
        send_byte(8'h05);
        send_byte(8'h03);
        check("div_03", {24'b0, bus.clk_div}, 32'h03);
        tick();
        send_byte(8'h77);
        tx0 = tx_cnt;
        repeat (3) tick();
        check("ovr_held", tx_cnt, tx0);
        bus.tx_busy = 1'b0;
        #1;
        check("ovr_txs", {31'b0, bus.tx_start}, 32'd1);
        check("ovr_txd", {24'b0, bus.tx_data}, 32'h55);
        repeat (4) tick();
        check("ovr_single", tx_cnt, tx0 + 1);
        send_byte(8'h06);
        wait_tx("ovr_status1", 8'h04);
        send_byte(8'h06);
        wait_tx("ovr_status2", 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
